// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy
// flags, synchronous flush and sticky overflow/underflow indicators.
module sync_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int FWFT       = 0,
   parameter int AFULL_LVL  = 12,
   parameter int AEMPTY_LVL = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush_i,
   input  logic                     wr_en_i,
   input  logic [DATA_WIDTH-1:0]    wr_data_i,
   input  logic                     rd_en_i,
   output logic [DATA_WIDTH-1:0]    rd_data_o,
   output logic                     rd_valid_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     almost_full_o,
   output logic                     almost_empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o,
   output logic                     underflow_o
);

   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;

   localparam ptr_t DEPTH_C  = ptr_t'(DEPTH);
   localparam ptr_t AFULL_C  = ptr_t'(AFULL_LVL);
   localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_LVL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   ptr_t count;
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;
   logic wr_acc, rd_acc;
   logic [AW-1:0] wr_idx, rd_idx;

   // Extra pointer MSB separates full (diff == DEPTH) from empty (diff == 0).
   always_comb begin
      count          = wr_ptr_q - rd_ptr_q;
      full_o         = (count == DEPTH_C);
      empty_o        = (count == '0);
      almost_full_o  = (count >= AFULL_C);
      almost_empty_o = (count <= AEMPTY_C);
      count_o        = count;
      overflow_o     = overflow_q;
      underflow_o    = underflow_q;
      wr_idx         = wr_ptr_q[AW-1:0];
      rd_idx         = rd_ptr_q[AW-1:0];
   end

   // Flush masks both requests, so neither storage nor error flags see them.
   assign wr_acc = wr_en_i & ~full_o  & ~flush_i;
   assign rd_acc = rd_en_i & ~empty_o & ~flush_i;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush_i) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
         if (rd_acc)
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
         if (wr_en_i && full_o)
            overflow_d = 1'b1;
         if (rd_en_i && empty_o)
            underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_idx] <= wr_data_i;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data_o  = mem[rd_idx];
         assign rd_valid_o = ~empty_o;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
         logic                  rd_valid_q, rd_valid_d;

         always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
            if (flush_i) begin
               rd_data_d = '0;
            end else if (rd_acc) begin
               rd_data_d  = mem[rd_idx];
               rd_valid_d = 1'b1;
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_data_q  <= rd_data_d;
               rd_valid_q <= rd_valid_d;
            end
         end

         assign rd_data_o  = rd_data_q;
         assign rd_valid_o = rd_valid_q;
      end
   endgenerate

endmodule
